// File: rtl/remote_cmd_link.sv
// remote_cmd_link: host-side UART command link for the Knight's Tour remote.
// Sends a 16-bit command as two 8N1 frames (high byte first) and receives
// a one-byte response from the robot.
// Optional feature macro: RESP_TIMEOUT_EN adds a response-timeout counter
// that pulses resp_timeout when the robot stays silent after a command.
module remote_cmd_link #(
    parameter int unsigned BAUD_DIV    = 2604,
    parameter logic [23:0] TIMEOUT_CYC = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd,
    input  logic        send_cmd,
    output logic        cmd_sent,
    output logic        TX,
    input  logic        RX,
    output logic [7:0]  resp,
    output logic        resp_rdy,
    output logic        resp_timeout
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

    // ---------------- transmit side ----------------
    typedef enum logic [1:0] {TX_IDLE, TX_HIGH, TX_LOW} tx_state_t;
    tx_state_t     tx_state, tx_next;
    logic [CW-1:0] tx_baud;
    logic [3:0]    tx_bit;
    logic [15:0]   shadow;
    logic [7:0]    tx_byte;
    logic [9:0]    tx_frame;
    logic          tx_accept, tx_bit_end, tx_frame_end, tx_done;

    // Commands are only taken while the line is idle; strobes during a frame are dropped.
    assign tx_accept    = (tx_state == TX_IDLE) && send_cmd;
    assign tx_bit_end   = (tx_baud == BAUD_LAST);
    assign tx_frame_end = tx_bit_end && (tx_bit == 4'd9);
    assign tx_byte      = (tx_state == TX_HIGH) ? shadow[15:8] : shadow[7:0];
    assign tx_frame     = {1'b1, tx_byte, 1'b0};
    // Line is driven straight from registered state, so start bit appears on the accepting edge.
    assign TX           = (tx_state == TX_IDLE) ? 1'b1 : tx_frame[tx_bit];

    // TX state register
    always_ff @(posedge clk) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_next;
    end

    // TX next-state: HIGH byte frame, then LOW byte frame back to back
    always_comb begin
        tx_next = tx_state;
        tx_done = 1'b0;
        case (tx_state)
            TX_IDLE: if (send_cmd) tx_next = TX_HIGH;
            TX_HIGH: if (tx_frame_end) tx_next = TX_LOW;
            TX_LOW:  if (tx_frame_end) begin
                         tx_next = TX_IDLE;
                         tx_done = 1'b1;
                     end
            default: tx_next = TX_IDLE;
        endcase
    end

    // TX datapath: shadow capture, baud/bit counters, cmd_sent flag
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_baud  <= '0;
            tx_bit   <= 4'd0;
            shadow   <= 16'h0000;
            cmd_sent <= 1'b0;
        end else if (tx_accept) begin
            shadow   <= cmd;
            cmd_sent <= 1'b0;
            tx_baud  <= '0;
            tx_bit   <= 4'd0;
        end else if (tx_state != TX_IDLE) begin
            if (tx_bit_end) begin
                tx_baud <= '0;
                tx_bit  <= (tx_bit == 4'd9) ? 4'd0 : tx_bit + 4'd1;
            end else begin
                tx_baud <= tx_baud + 1'b1;
            end
            if (tx_done) cmd_sent <= 1'b1;
        end
    end

    // ---------------- receive side ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    rx_state_t     rx_state, rx_next;
    logic          rx_s1, rx_s2, rx_prev;
    logic [CW-1:0] rx_baud;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_fall, rx_half, rx_tick, rx_load;

    assign rx_fall = rx_prev & ~rx_s2;
    assign rx_half = (rx_baud == HALF_LAST);
    assign rx_tick = (rx_baud == BAUD_LAST);

    // RX state register
    always_ff @(posedge clk) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_next;
    end

    // RX next-state: validate start bit at half-bit, then sample mid-bit
    always_comb begin
        rx_next = rx_state;
        rx_load = 1'b0;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            RX_START: if (rx_half) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_tick) begin
                          rx_next = RX_IDLE;
                          rx_load = 1'b1;  // stop bit value is not checked
                      end
            default:  rx_next = RX_IDLE;
        endcase
    end

    // RX datapath: synchronizer, baud counter, shift register, response register
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_baud  <= '0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'h00;
            resp     <= 8'h00;
            resp_rdy <= 1'b0;
        end else begin
            rx_s1    <= RX;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            resp_rdy <= rx_load;
            if (rx_load) resp <= rx_shift;
            // Restarting at the half-bit point aligns later samples to mid-bit.
            if (rx_state == RX_IDLE || (rx_state == RX_START && rx_half))
                rx_baud <= '0;
            else
                rx_baud <= rx_tick ? '0 : rx_baud + 1'b1;
            if (rx_state == RX_IDLE)
                rx_bit <= 3'd0;
            else if (rx_state == RX_DATA && rx_tick) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
        end
    end

    // ---------------- optional response timeout ----------------
`ifdef RESP_TIMEOUT_EN
    logic [23:0] to_cnt;
    logic        to_run, to_pulse;

    // Wait for a reply after the command completes; give up after TIMEOUT_CYC cycles.
    always_ff @(posedge clk) begin
        if (rst || tx_accept) begin
            to_cnt   <= 24'd0;
            to_run   <= 1'b0;
            to_pulse <= 1'b0;
        end else begin
            to_pulse <= 1'b0;
            if (tx_done) begin
                to_run <= 1'b1;
                to_cnt <= 24'd0;
            end else if (to_run) begin
                if (rx_load) begin
                    to_run <= 1'b0;
                end else if (to_cnt == TIMEOUT_CYC - 24'd1) begin
                    to_run   <= 1'b0;
                    to_pulse <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + 24'd1;
                end
            end
        end
    end
    assign resp_timeout = to_pulse;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign resp_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_remote_cmd_link.sv
// Testbench for remote_cmd_link at BAUD_DIV=16: vector table, corner sequences,
// and randomized commands/responses checked against a byte-level line model.
module tb_remote_cmd_link;
    localparam int B = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cmd = 16'h0000;
    logic        send_cmd = 1'b0;
    logic        RX = 1'b1;
    logic        cmd_sent, TX, resp_rdy, resp_timeout;
    logic [7:0]  resp;

    remote_cmd_link #(.BAUD_DIV(B), .TIMEOUT_CYC(24'd1000)) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .send_cmd(send_cmd), .cmd_sent(cmd_sent),
        .TX(TX), .RX(RX), .resp(resp), .resp_rdy(resp_rdy), .resp_timeout(resp_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: decodes TX frames, timestamps edges, counts resp_rdy pulses.
    byte unsigned txq[$];
    int           fallq[$];
    bit           mon_busy = 0;
    int           mon_t = 0, k = 0, frame_err = 0;
    logic [9:0]   mon_bits;
    logic         cs_prev = 1'b0;
    int           cs_rise_cyc = 0, rdy_cnt = 0, rdy_cyc = 0, rx_start_cyc = 0, to_cnt = 0;

    always @(negedge clk) begin
        if (rst) mon_busy = 0;
        else if (!mon_busy) begin
            if (TX === 1'b0) begin mon_busy = 1; mon_t = 0; fallq.push_back(cyc); end
        end else begin
            mon_t++;
            if (mon_t >= B/2 && (mon_t - B/2) % B == 0) begin
                k = (mon_t - B/2) / B;
                mon_bits[k] = TX;
                if (k == 9) begin
                    mon_busy = 0;
                    if (mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1) frame_err++;
                    txq.push_back(mon_bits[8:1]);
                end
            end
        end
        if (!rst && cmd_sent === 1'b1 && cs_prev !== 1'b1) cs_rise_cyc = cyc;
        cs_prev = cmd_sent;
        if (resp_rdy === 1'b1) begin rdy_cnt++; rdy_cyc = cyc; end
        if (resp_timeout !== 1'b0) to_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [15:0] c);
        cmd = c; send_cmd = 1'b1; tick(); send_cmd = 1'b0;
    endtask

    task automatic wait_sent(input string nm);
        int n = 0;
        while (cmd_sent !== 1'b1 && n < 30*B) begin tick(); n++; end
        chk({nm, "_sent_bound"}, {31'd0, cmd_sent}, 32'd1);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        rx_start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin RX = f[i]; tick(B); end
    endtask

    function automatic logic [15:0] first_two();
        if (txq.size() >= 2) return {txq[0], txq[1]};
        return 16'hxxxx;
    endfunction

    typedef struct {
        logic [15:0] c;
        logic [7:0]  rxb;
        logic [7:0]  hi, lo, exp_resp;
    } vec_t;

    initial begin : main
        vec_t vecs[5];
        int   r0, rdy_total;
        rdy_total = 0;
        vecs[0] = '{16'h2A5C, 8'hA5, 8'h2A, 8'h5C, 8'hA5};
        vecs[1] = '{16'h0000, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{16'hFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[3] = '{16'h8001, 8'h3C, 8'h80, 8'h01, 8'h3C};
        vecs[4] = '{16'h7FFE, 8'hC3, 8'h7F, 8'hFE, 8'hC3};

        // reset state held over two cycles
        tick(2);
        chk("rst_tx", {31'd0, TX}, 32'd1);
        chk("rst_cmd_sent", {31'd0, cmd_sent}, 32'd0);
        chk("rst_resp", {24'd0, resp}, 32'h00);
        chk("rst_resp_rdy", {31'd0, resp_rdy}, 32'd0);
        chk("rst_timeout", {31'd0, resp_timeout}, 32'd0);
        rst = 1'b0;
        tick(3);

        // table: command bytes, cmd_sent timing, concurrent response frame
        for (int v = 0; v < 5; v++) begin
            txq.delete(); fallq.delete(); r0 = rdy_cnt;
            send(vecs[v].c);
            chk($sformatf("v%0d_start_lat", v), {31'd0, TX}, 32'd0);
            chk($sformatf("v%0d_busy", v), {31'd0, cmd_sent}, 32'd0);
            rx_byte(vecs[v].rxb);
            rdy_total++;
            wait_sent($sformatf("v%0d", v));
            tick(B);
            chk($sformatf("v%0d_bytes", v), {16'd0, first_two()}, {16'd0, vecs[v].hi, vecs[v].lo});
            chk($sformatf("v%0d_nbytes", v), txq.size(), 2);
            chk($sformatf("v%0d_sent_dly", v), (fallq.size() > 0) ? cs_rise_cyc - fallq[0] : -1, 20*B);
            chk($sformatf("v%0d_resp", v), {24'd0, resp}, {24'd0, vecs[v].exp_resp});
            chk($sformatf("v%0d_rdy_cnt", v), rdy_cnt - r0, 1);
            chk($sformatf("v%0d_rdy_win", v),
                {31'd0, (rdy_cyc - rx_start_cyc >= 9*B + B/2) && (rdy_cyc - rx_start_cyc <= 9*B + B/2 + 6)}, 32'd1);
        end

        // strobe 40 cycles into a frame with a new cmd is ignored
        txq.delete();
        send(16'h2A5C);
        tick(39);
        cmd = 16'hFFFF; send_cmd = 1'b1; tick(); send_cmd = 1'b0;
        wait_sent("ign");
        tick(12*B);
        chk("ign_bytes", {16'd0, first_two()}, 32'h2A5C);
        chk("ign_nbytes", txq.size(), 2);

        // strobe on the very edge the LOW frame completes is ignored
        txq.delete();
        send(16'h1357);
        tick(20*B - 1);
        cmd = 16'hBEEF; send_cmd = 1'b1; tick(); send_cmd = 1'b0;
        chk("edge_sent", {31'd0, cmd_sent}, 32'd1);
        tick(12*B);
        chk("edge_nbytes", txq.size(), 2);
        chk("edge_bytes", {16'd0, first_two()}, 32'h1357);
        chk("edge_tx_idle", {31'd0, TX}, 32'd1);

        // short RX glitch produces nothing
        r0 = rdy_cnt;
        RX = 1'b0; tick(4); RX = 1'b1;
        tick(12*B);
        chk("glitch_rdy", rdy_cnt - r0, 0);
        chk("glitch_resp", {24'd0, resp}, 32'hC3);

        // randomized: command, optional late strobe, optional response byte
        for (int r = 0; r < 8; r++) begin
            logic [15:0] c, c2;
            logic [7:0]  rb;
            byte unsigned expq[$];
            int          extra;
            bit          acc2;
            c = 16'($urandom); c2 = 16'($urandom); rb = 8'($urandom);
            extra = $urandom_range(1, 22*B);
            // line model: link busy for 20 bit times after an accepted strobe
            acc2 = (extra + 1) > 20*B;
            expq.delete();
            expq.push_back(c[15:8]); expq.push_back(c[7:0]);
            if (acc2) begin expq.push_back(c2[15:8]); expq.push_back(c2[7:0]); end
            txq.delete(); r0 = rdy_cnt;
            send(c);
            fork
                begin tick(extra); cmd = c2; send_cmd = 1'b1; tick(); send_cmd = 1'b0; end
                begin if (r % 2 == 1) rx_byte(rb); end
            join
            if (r % 2 == 1) rdy_total++;
            wait_sent($sformatf("rnd%0d", r));
            tick(12*B);
            chk($sformatf("rnd%0d_nbytes", r), txq.size(), expq.size());
            for (int i = 0; i < expq.size(); i++)
                chk($sformatf("rnd%0d_byte%0d", r, i), (i < txq.size()) ? {24'd0, txq[i]} : 32'hxxxxxxxx,
                    {24'd0, expq[i]});
            if (r % 2 == 1) chk($sformatf("rnd%0d_resp", r), {24'd0, resp}, {24'd0, rb});
            chk($sformatf("rnd%0d_rdy", r), rdy_cnt - r0, (r % 2 == 1) ? 1 : 0);
        end

        // reset 100 cycles into a frame, with an RX frame also in flight
        txq.delete(); r0 = rdy_cnt;
        send(16'h1234);
        RX = 1'b0; tick(B); RX = 1'b1;
        tick(99 - B);
        rst = 1'b1; tick();
        chk("mid_rst_tx", {31'd0, TX}, 32'd1);
        chk("mid_rst_sent", {31'd0, cmd_sent}, 32'd0);
        chk("mid_rst_resp", {24'd0, resp}, 32'h00);
        rst = 1'b0;
        tick(12*B);
        chk("mid_rst_rdy", rdy_cnt - r0, 0);
        chk("mid_rst_nbytes", txq.size(), 0);
        send(16'h0000);
        wait_sent("post_rst");
        tick(B);
        chk("post_rst_bytes", {15'd0, txq.size() == 2, first_two()}, {15'd0, 1'b1, 16'h0000});
        chk("frame_errors", frame_err, 0);
        chk("rdy_total", rdy_cnt, rdy_total);
        chk("timeout_never", to_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
